// File: rtl/image_pkg.sv
// Shared constants, FSM state type and beat record for the 28x28 image decompressor.
package image_pkg;

  localparam int IMG_DIM = 28;
  localparam int SCALE   = 8;
  localparam int OUT_DIM = IMG_DIM * SCALE;
  localparam int PIX_W   = 8;
  localparam int ADDR_W  = 10;
  localparam int CNT_W   = $clog2(OUT_DIM);
  localparam int SUB_W   = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [PIX_W-1:0] THRESH = 8'h80;

  typedef enum logic [1:0] {IDLE, RUN, DONE} decomp_state_t;

  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic             sof;
    logic             eol;
    logic             eof;
  } pix_beat_t;

  function automatic logic [PIX_W-1:0] binarize(input logic [PIX_W-1:0] w);
    return (w >= THRESH) ? {PIX_W{1'b1}} : '0;
  endfunction

endpackage

// File: rtl/pix_skid_buf.sv
// Two-entry valid/ready buffer for output beats; registered outputs, full throughput at one
// beat per cycle, and the upstream stalls only when both entries are occupied.
module pix_skid_buf
  import image_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  pix_beat_t in_beat,
  input  logic      in_valid,
  output logic      in_ready,
  output pix_beat_t out_beat,
  output logic      out_valid,
  input  logic      out_ready
);

  pix_beat_t [1:0] entry_q;
  logic            wr_ptr_reg;
  logic            rd_ptr_reg;
  logic [1:0]      count_reg;
  logic [1:0]      count_next;
  logic            push;
  logic            pop;

  assign in_ready  = (count_reg != 2'd2);
  assign out_valid = (count_reg != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_beat  = entry_q[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      pix_beat_t entry_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          entry_reg <= '0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          entry_reg <= in_beat;
        end
      end

      assign entry_q[gi] = entry_reg;
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      count_reg <= count_next;
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
    end
  end

endmodule

// File: rtl/image_decompressor.sv
// Streams the 28x28 image RAM out upscaled by SCALE in raster order on a valid/ready pixel stream.
// Optional IMAGE_DECOMP_BINARIZE_EN: output pixels thresholded against THRESH to all-ones/zero.
module image_decompressor
  import image_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              pix_eof
);

  localparam logic [CNT_W-1:0]  PX_LAST  = CNT_W'(OUT_DIM - 1);
  localparam logic [CNT_W-1:0]  PX_LGRP  = CNT_W'(OUT_DIM - SCALE);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(SCALE - 1);
  localparam logic [SUB_W-1:0]  SUB_ONE  = SUB_W'(1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_DIM);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  decomp_state_t     state_reg, state_next;
  logic [CNT_W-1:0]  px_reg, px_next;
  logic [CNT_W-1:0]  py_reg, py_next;
  logic [SUB_W-1:0]  sx_reg, sx_next;
  logic [SUB_W-1:0]  sy_reg, sy_next;
  logic [ADDR_W-1:0] row_base_reg, row_base_next;
  logic [ADDR_W-1:0] raddr_reg, raddr_next;
  logic [PIX_W-1:0]  word_reg, word_next;
  logic              prod_done_reg, prod_done_next;

  logic [PIX_W-1:0]  src_word;
  logic              row_last;
  logic              frame_last;
  logic              eof_accept;
  pix_beat_t         in_beat;
  pix_beat_t         out_beat;
  logic              in_valid;
  logic              in_ready;
  logic              out_valid;

  // First beat of each group takes the fresh RAM word; the rest replay the held copy.
  assign src_word   = (sx_reg == '0) ? mem_rdata : word_reg;
  assign row_last   = (px_reg == PX_LAST);
  assign frame_last = row_last && (py_reg == PX_LAST);
  assign in_valid   = (state_reg == RUN) && !prod_done_reg;
  assign eof_accept = out_valid && pix_ready && out_beat.eof;

  always_comb begin
    in_beat     = '0;
`ifdef IMAGE_DECOMP_BINARIZE_EN
    in_beat.data = binarize(src_word);
`else
    in_beat.data = src_word;
`endif
    in_beat.sof = (px_reg == '0) && (py_reg == '0);
    in_beat.eol = row_last;
    in_beat.eof = frame_last;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (eof_accept) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    px_next        = px_reg;
    py_next        = py_reg;
    sx_next        = sx_reg;
    sy_next        = sy_reg;
    row_base_next  = row_base_reg;
    raddr_next     = raddr_reg;
    word_next      = word_reg;
    prod_done_next = prod_done_reg;

    if ((state_reg == IDLE) && start) begin
      px_next        = '0;
      py_next        = '0;
      sx_next        = '0;
      sy_next        = '0;
      row_base_next  = '0;
      raddr_next     = '0;
      prod_done_next = 1'b0;
    end else if (in_valid && in_ready) begin
      word_next = src_word;
      sx_next   = (sx_reg == SUB_LAST) ? '0 : sx_reg + SUB_ONE;
      if (row_last) begin
        px_next = '0;
        py_next = py_reg + CNT_ONE;
        sy_next = (sy_reg == SUB_LAST) ? '0 : sy_reg + SUB_ONE;
        if (sy_reg == SUB_LAST) row_base_next = row_base_reg + ROW_STEP;
      end else begin
        px_next = px_reg + CNT_ONE;
      end
      // Address moves on only when a group's word is consumed, so RAM stays <=2 words ahead.
      if (sx_reg == '0) begin
        if (px_reg != PX_LGRP)        raddr_next = raddr_reg + ADDR_ONE;
        else if (sy_reg != SUB_LAST)  raddr_next = row_base_reg;
        else if (py_reg == PX_LAST)   raddr_next = '0;
        else                          raddr_next = row_base_reg + ROW_STEP;
      end
      if (frame_last) prod_done_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      px_reg        <= '0;
      py_reg        <= '0;
      sx_reg        <= '0;
      sy_reg        <= '0;
      row_base_reg  <= '0;
      raddr_reg     <= '0;
      word_reg      <= '0;
      prod_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      px_reg        <= px_next;
      py_reg        <= py_next;
      sx_reg        <= sx_next;
      sy_reg        <= sy_next;
      row_base_reg  <= row_base_next;
      raddr_reg     <= raddr_next;
      word_reg      <= word_next;
      prod_done_reg <= prod_done_next;
    end
  end

  pix_skid_buf u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_beat   (in_beat),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_beat  (out_beat),
    .out_valid (out_valid),
    .out_ready (pix_ready)
  );

  assign busy      = (state_reg == RUN);
  assign done      = (state_reg == DONE);
  assign mem_raddr = raddr_reg;
  assign pix_valid = out_valid;
  assign pix_data  = out_beat.data;
  assign pix_sof   = out_valid && out_beat.sof;
  assign pix_eol   = out_valid && out_beat.eol;
  assign pix_eof   = out_valid && out_beat.eof;

endmodule
